// File: rtl/drink_pkg.sv
// ---------------------------------------------------------------------------
// drink_pkg
// Shared types and widths for the drink reminder controller.
//   state_e   : FSM state; the encoding is what drives the debug/LED pins
//   LEVEL_W   : width of the debounced water level from the level checker
//   MISS_W    : width of the saturating missed-alert counter
//   max3      : helper used to size the shared phase timer
// ---------------------------------------------------------------------------
package drink_pkg;

   localparam int LEVEL_W = 4;
   localparam int MISS_W  = 4;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_ALERT  = 2'd1,
      ST_SNOOZE = 2'd2,
      ST_EMPTY  = 2'd3
   } state_e;

   // Largest of three tick counts; the one timer is shared by all phases,
   // so it has to be wide enough for the longest of them.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/drink_reminder_ctrl_if.sv
// ---------------------------------------------------------------------------
// drink_reminder_ctrl_if
// Bundles the level-checker input and the buzzer/LED outputs of the
// reminder controller.
//   water_level : debounced level, 0 = empty, 15 = full
//   ack         : one-cycle user acknowledge, already in the clk domain
//   buzzer      : high while alerting
//   refill_led  : high while the bottle is empty
//   state       : raw FSM state for debug LEDs
//   miss_count  : alerts since the last drink, saturating
// master = level checker / GPIO side, slave = the controller.
// ---------------------------------------------------------------------------
interface drink_reminder_ctrl_if;
   import drink_pkg::*;

   logic [LEVEL_W-1:0] water_level;
   logic               ack;
   logic               buzzer;
   logic               refill_led;
   logic [1:0]         state;
   logic [MISS_W-1:0]  miss_count;

   modport master (
      output water_level, ack,
      input  buzzer, refill_led, state, miss_count
   );

   modport slave (
      input  water_level, ack,
      output buzzer, refill_led, state, miss_count
   );

endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler that produces the timing tick of the reminder.
//   clk   : system clock
//   reset : asynchronous, active-low
//   tick  : one-cycle pulse every TICK_DIV clk cycles
// The counter is never restarted by drinks, so the first tick after a
// drink may cover only part of a tick period.
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Count 0..TICK_DIV-1 and wrap; the tick is decoded from the register
   // so it is a clean, glitch-free single-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == CNT_LAST);

endmodule

// File: rtl/drink_reminder_ctrl.sv
// ---------------------------------------------------------------------------
// drink_reminder_ctrl
// Reminder scheduler for the water bottle. Watches the debounced level for
// drinks (level drop), refills (level rise) and empty, times the interval
// since the last drink and sequences the buzzer through alert/snooze.
//   clk   : system clock
//   reset : asynchronous, active-low; clears all state while low
//   bus   : slave side of drink_reminder_ctrl_if
//             in  water_level, ack
//             out buzzer, refill_led, state, miss_count
// All outputs come straight from registers; there is no combinational
// path from water_level or ack to any output.
// ---------------------------------------------------------------------------
module drink_reminder_ctrl
   import drink_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int REMIND_TICKS = 1800,
   parameter int ALERT_TICKS  = 10,
   parameter int SNOOZE_TICKS = 300,
   parameter int MIN_DROP     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   drink_reminder_ctrl_if.slave  bus
);

   localparam int MAX_TICKS = max3(REMIND_TICKS, ALERT_TICKS, SNOOZE_TICKS);
   localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [TIMER_W-1:0] REMIND_LAST = TIMER_W'(REMIND_TICKS - 1);
   localparam logic [TIMER_W-1:0] ALERT_LAST  = TIMER_W'(ALERT_TICKS - 1);
   localparam logic [TIMER_W-1:0] SNOOZE_LAST = TIMER_W'(SNOOZE_TICKS - 1);
   localparam logic [LEVEL_W:0]   DROP_V      = (LEVEL_W + 1)'(MIN_DROP);

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [LEVEL_W-1:0] ref_q, ref_d;
   logic [MISS_W-1:0]  miss_q, miss_d;

   logic tick;
   logic level_empty;
   logic drink;
   logic refill;

   function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // The drink compare is done one bit wider so level + MIN_DROP cannot
   // wrap past 15 and fake a drink on a full bottle.
   assign level_empty = (bus.water_level == '0);
   assign drink       = !level_empty &&
                        (({1'b0, bus.water_level} + DROP_V) <= {1'b0, ref_q});
   assign refill      = (bus.water_level > ref_q);

   // Registered state: FSM, shared phase timer, accepted level and the
   // missed-alert counter all update together on the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
         timer_q <= '0;
         ref_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ref_q   <= ref_d;
         miss_q  <= miss_d;
      end
   end

   // Next-state logic. Priority is empty, then drink (leaving EMPTY is
   // handled the same way as a drink), then ack, then the tick-driven
   // timer. A refill only moves the reference level and leaves the
   // running interval alone, so topping up does not postpone an alert.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ref_d   = ref_q;
      miss_d  = miss_q;

      if (level_empty) begin
         state_d = ST_EMPTY;
         timer_d = '0;
      end else if ((state_q == ST_EMPTY) || drink) begin
         state_d = ST_WAIT;
         timer_d = '0;
         miss_d  = '0;
         ref_d   = bus.water_level;
      end else begin
         if (refill) begin
            ref_d = bus.water_level;
         end

         case (state_q)
            ST_WAIT: begin
               if (tick) begin
                  if (timer_q == REMIND_LAST) begin
                     state_d = ST_ALERT;
                     timer_d = '0;
                     miss_d  = sat_inc(miss_q);
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end

            ST_ALERT: begin
               if (bus.ack) begin
                  state_d = ST_SNOOZE;
                  timer_d = '0;
               end else if (tick) begin
                  if (timer_q == ALERT_LAST) begin
                     state_d = ST_SNOOZE;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end

            ST_SNOOZE: begin
               if (tick) begin
                  if (timer_q == SNOOZE_LAST) begin
                     state_d = ST_ALERT;
                     timer_d = '0;
                     miss_d  = sat_inc(miss_q);
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign bus.buzzer     = (state_q == ST_ALERT);
   assign bus.refill_led = (state_q == ST_EMPTY);
   assign bus.state      = state_q;
   assign bus.miss_count = miss_q;

endmodule

// File: doc/drink_reminder_ctrl.md
# drink_reminder_ctrl

Reminder scheduler for the water bottle. It consumes the debounced 4-bit water level from the level checker and detects drinking events and empty/refill conditions. It times the interval since the last drink and sequences the buzzer through alert, snooze and repeat. It sits between the level-checker output and the buzzer/LED GPIO drivers.

## Interface
- TICK_DIV, 50_000_000: clk cycles per timing tick (1 s at 50 MHz).
- REMIND_TICKS, 1800: ticks without a drink before the first alert.
- ALERT_TICKS, 10: ticks the buzzer sounds before auto-snooze.
- SNOOZE_TICKS, 300: ticks of silence between repeated alerts.
- MIN_DROP, 1: level decrease (in level LSBs) that counts as a drink.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- water_level  in  4  debounced level; 0 = empty, 15 = full.
- ack  in  1  user acknowledge, one-cycle pulse, already synchronized to clk.
- buzzer  out  1  high while in ALERT.
- refill_led  out  1  high while in EMPTY.
- state  out  2  current state encoding, for debug/LEDs.
- miss_count  out  4  alerts issued since the last drink, saturating at 15.

## Operation
- States: WAIT=0, ALERT=1, SNOOZE=2, EMPTY=3.
- Prescaler runs freely 0..TICK_DIV-1. `tick` is a one-cycle pulse when the count equals TICK_DIV-1. Drinks do not reset the prescaler, so the first tick after a drink may be partial.
- ref_level holds the last accepted level.
- drink = (water_level + MIN_DROP <= ref_level), computed 5 bits wide with no wrap, and water_level != 0.
- refill = water_level > ref_level. Refill loads ref_level without touching the timer or miss_count.
- Per-cycle priority, highest first: empty (water_level==0), drink, ack, tick/timer.
- Any state with water_level==0 goes to EMPTY. The timer is cleared and held. ref_level is left unchanged.
- EMPTY exits to WAIT when water_level!=0. ref_level loads water_level, the timer clears and miss_count clears.
- drink in WAIT, ALERT or SNOOZE goes to WAIT. ref_level loads water_level, the timer clears and miss_count clears.
- WAIT: on tick, timer++. On the tick where timer==REMIND_TICKS-1, go to ALERT, clear the timer and increment miss_count (saturating).
- ALERT: ack goes to SNOOZE and clears the timer. On the tick where timer==ALERT_TICKS-1, go to SNOOZE and clear the timer.
- SNOOZE: ack is ignored. On the tick where timer==SNOOZE_TICKS-1, go to ALERT, clear the timer and increment miss_count (saturating).
- ack in WAIT or EMPTY is ignored.
- The timer is sized to $clog2 of the largest tick parameter and never exceeds its terminal value.

## Timing
- Reset values: state=WAIT, buzzer=0, refill_led=0, miss_count=0, timer=0, prescaler=0, ref_level=0.
- After reset release with a nonzero level, ref_level loads that level on the first edge (treated as a refill).
- All decisions are registered. A condition sampled at edge N is visible on state, buzzer, refill_led and miss_count after edge N.
- buzzer, refill_led and state decode directly from the state register. miss_count is a register. None has a combinational path from inputs.
- Latency from a water_level or ack change to the output response is exactly 1 clk.
- Simultaneous drink and ack: drink wins and the next state is WAIT.
- Simultaneous ack and the alert-timeout tick: next state is SNOOZE and the timer is cleared (same result either way).
- Reset asserted mid-ALERT: buzzer drops asynchronously.

## Structure
- Package drink_pkg: state_e enum (2-bit, encodings above) and LEVEL_W=4.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick).
- FSM, timer, ref_level and miss_count live in drink_reminder_ctrl.

## Test plan
Bench parameters: TICK_DIV=4, REMIND_TICKS=3, ALERT_TICKS=2, SNOOZE_TICKS=2, MIN_DROP=1.
- Hold level 8 after reset -> ref_level=8. buzzer rises 1 clk after the 3rd tick. miss_count=1.
- Let it run with no ack -> buzzer high for 2 ticks, SNOOZE for 2 ticks, ALERT again. miss_count=2.
- In ALERT, pulse ack -> state=SNOOZE next clk and buzzer=0. Drop level 8->7 in SNOOZE -> WAIT next clk, miss_count=0, timer restarts.
- Drive level 0 in ALERT -> EMPTY next clk, refill_led=1, buzzer=0. Raise the level to 12 -> WAIT, ref_level=12, miss_count=0.
- Raise level 5->9 in WAIT (refill) -> ref_level=9, timer not cleared, alert still at the original 3rd tick.
- In ALERT, pulse ack and drop level 9->8 in the same cycle -> WAIT (drink priority). Assert reset mid-ALERT -> all outputs 0 immediately.
